// File: rtl/bananachine_pkg.sv
// Shared encodings for the Bananachine control path: states, instruction classes,
// opcode/extended-opcode constants, ALU function codes and mux select encodings.
package bananachine_pkg;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecAlu, StMemLoad, StLoadWb, StMemStore, StBranch, StJump
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJcond, ClsJal, ClsIllegal
  } cls_e;

  localparam logic [3:0] OP_RTYPE   = 4'h0;
  localparam logic [3:0] OP_ANDI    = 4'h1;
  localparam logic [3:0] OP_ORI     = 4'h2;
  localparam logic [3:0] OP_XORI    = 4'h3;
  localparam logic [3:0] OP_SPECIAL = 4'h4;
  localparam logic [3:0] OP_ADDI    = 4'h5;
  localparam logic [3:0] OP_SUBI    = 4'h9;
  localparam logic [3:0] OP_CMPI    = 4'hB;
  localparam logic [3:0] OP_BCOND   = 4'hC;
  localparam logic [3:0] OP_MOVI    = 4'hD;

  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  // ADD is code 0 so the idle alu_sel value is also the all-zero reset value.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_MOV = 4'd5;

  localparam logic [1:0] PC_SRC_INC  = 2'd0;
  localparam logic [1:0] PC_SRC_DISP = 2'd1;
  localparam logic [1:0] PC_SRC_REG  = 2'd2;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC  = 2'd2;

  // Immediate opcodes reuse the R-type extended codes, so one map serves both.
  function automatic logic is_alu_fn(input logic [3:0] fn);
    return (fn == EXT_AND) || (fn == EXT_OR) || (fn == EXT_XOR) || (fn == EXT_ADD) ||
           (fn == EXT_SUB) || (fn == EXT_CMP) || (fn == EXT_MOV);
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] fn);
    logic [3:0] code;
    code = ALU_ADD;
    case (fn)
      EXT_AND: code = ALU_AND;
      EXT_OR:  code = ALU_OR;
      EXT_XOR: code = ALU_XOR;
      EXT_SUB: code = ALU_SUB;
      EXT_CMP: code = ALU_SUB;
      EXT_MOV: code = ALU_MOV;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction classifier: maps op_code/ext_op_code to an instruction
// class plus the ALU attributes needed by the execute state.
module control_decode
  import bananachine_pkg::*;
(
  input  logic [3:0] i_op_code,
  input  logic [3:0] i_ext_op_code,
  output logic [2:0] o_cls,
  output logic [3:0] o_alu_sel,
  output logic       o_imm,
  output logic       o_writes_reg,
  output logic       o_sets_flags
);

  cls_e       w_cls;
  logic [3:0] w_fn;

  assign w_fn = (i_op_code == OP_RTYPE) ? i_ext_op_code : i_op_code;

  always_comb begin
    w_cls        = ClsIllegal;
    o_alu_sel    = ALU_ADD;
    o_imm        = 1'b0;
    o_writes_reg = 1'b0;
    o_sets_flags = 1'b0;

    if (i_op_code == OP_RTYPE) begin
      if (is_alu_fn(i_ext_op_code)) w_cls = ClsAlu;
    end else if (i_op_code == OP_SPECIAL) begin
      case (i_ext_op_code)
        EXT_LOAD:  w_cls = ClsLoad;
        EXT_STOR:  w_cls = ClsStore;
        EXT_JAL:   w_cls = ClsJal;
        EXT_JCOND: w_cls = ClsJcond;
        default:   w_cls = ClsIllegal;
      endcase
    end else if (i_op_code == OP_BCOND) begin
      w_cls = ClsBranch;
    end else if (is_alu_fn(i_op_code)) begin
      w_cls = ClsAlu;
      o_imm = 1'b1;
    end

    if (w_cls == ClsAlu) begin
      o_alu_sel    = alu_code(w_fn);
      o_writes_reg = (w_fn != EXT_CMP);
      o_sets_flags = (w_fn == EXT_ADD) || (w_fn == EXT_SUB) || (w_fn == EXT_CMP);
    end
  end

  assign o_cls = w_cls;

endmodule

// File: rtl/control_fsm.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer for the Bananachine core.
// Only the state is registered; all datapath enables are decoded from state.
module control_fsm
  import bananachine_pkg::*;
#(
  parameter int unsigned OP_CODE_BITS     = 4,
  parameter int unsigned EXT_OP_CODE_BITS = 4,
  parameter int unsigned ALU_SEL_BITS     = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [OP_CODE_BITS-1:0]     i_op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] i_ext_op_code,
  input  logic                        i_cond_true,
  input  logic                        i_mem_ready,
  output logic                        o_instruction_en,
  output logic                        o_pc_en,
  output logic [1:0]                  o_pc_src,
  output logic                        o_reg_write,
  output logic [1:0]                  o_wb_src,
  output logic                        o_alu_b_src,
  output logic [ALU_SEL_BITS-1:0]     o_alu_sel,
  output logic                        o_flag_en,
  output logic                        o_mem_req,
  output logic                        o_mem_we,
  output logic                        o_addr_src,
  output logic                        o_illegal
);

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] w_cls;
  logic [3:0] w_alu_sel;
  logic       w_imm;
  logic       w_writes_reg;
  logic       w_sets_flags;

  control_decode u_decode (
    .i_op_code     (i_op_code),
    .i_ext_op_code (i_ext_op_code),
    .o_cls         (w_cls),
    .o_alu_sel     (w_alu_sel),
    .o_imm         (w_imm),
    .o_writes_reg  (w_writes_reg),
    .o_sets_flags  (w_sets_flags)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StFetch;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    o_instruction_en = 1'b0;
    o_pc_en          = 1'b0;
    o_pc_src         = PC_SRC_INC;
    o_reg_write      = 1'b0;
    o_wb_src         = WB_SRC_ALU;
    o_alu_b_src      = 1'b0;
    o_alu_sel        = ALU_ADD;
    o_flag_en        = 1'b0;
    o_mem_req        = 1'b0;
    o_mem_we         = 1'b0;
    o_addr_src       = 1'b0;
    o_illegal        = 1'b0;

    // Reset gates every output so a pending memory request drops immediately.
    if (!i_reset) begin
      unique case (r_state)
        StFetch: begin
          o_mem_req = 1'b1;
          if (i_mem_ready) begin
            o_instruction_en = 1'b1;
            o_pc_en          = 1'b1;
            w_state_next     = StDecode;
          end
        end
        StDecode: begin
          case (w_cls)
            ClsAlu:    w_state_next = StExecAlu;
            ClsLoad:   w_state_next = StMemLoad;
            ClsStore:  w_state_next = StMemStore;
            ClsBranch: w_state_next = StBranch;
            ClsJcond:  w_state_next = StJump;
            ClsJal:    w_state_next = StJump;
            default: begin
              o_illegal    = 1'b1;
              w_state_next = StFetch;
            end
          endcase
        end
        StExecAlu: begin
          o_alu_sel    = w_alu_sel;
          o_alu_b_src  = w_imm;
          o_reg_write  = w_writes_reg;
          o_flag_en    = w_sets_flags;
          w_state_next = StFetch;
        end
        StMemLoad: begin
          o_mem_req  = 1'b1;
          o_addr_src = 1'b1;
          if (i_mem_ready) w_state_next = StLoadWb;
        end
        StLoadWb: begin
          o_reg_write  = 1'b1;
          o_wb_src     = WB_SRC_MEM;
          w_state_next = StFetch;
        end
        StMemStore: begin
          o_mem_req  = 1'b1;
          o_mem_we   = 1'b1;
          o_addr_src = 1'b1;
          if (i_mem_ready) w_state_next = StFetch;
        end
        StBranch: begin
          o_pc_en      = i_cond_true;
          o_pc_src     = PC_SRC_DISP;
          w_state_next = StFetch;
        end
        StJump: begin
          o_pc_src = PC_SRC_REG;
          if (w_cls == ClsJal) begin
            o_reg_write = 1'b1;
            o_wb_src    = WB_SRC_PC;
            o_pc_en     = 1'b1;
          end else begin
            o_pc_en = i_cond_true;
          end
          w_state_next = StFetch;
        end
        default: w_state_next = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: expected output vectors are queued as each step is
// driven and checked against the DUT at the following falling edge.
module tb_control_fsm;
  import bananachine_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op_code;
  logic [3:0] ext_op_code;
  logic       cond_true;
  logic       mem_ready;
  logic       instruction_en, pc_en, reg_write, alu_b_src, flag_en;
  logic       mem_req, mem_we, addr_src, illegal;
  logic [1:0] pc_src, wb_src;
  logic [3:0] alu_sel;
  logic [16:0] obs;

  logic [16:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [16:0] zero_v, f_done, f_wait, ld_req, st_req;

  always #5 clk = ~clk;

  control_fsm dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_op_code        (op_code),
    .i_ext_op_code    (ext_op_code),
    .i_cond_true      (cond_true),
    .i_mem_ready      (mem_ready),
    .o_instruction_en (instruction_en),
    .o_pc_en          (pc_en),
    .o_pc_src         (pc_src),
    .o_reg_write      (reg_write),
    .o_wb_src         (wb_src),
    .o_alu_b_src      (alu_b_src),
    .o_alu_sel        (alu_sel),
    .o_flag_en        (flag_en),
    .o_mem_req        (mem_req),
    .o_mem_we         (mem_we),
    .o_addr_src       (addr_src),
    .o_illegal        (illegal)
  );

  assign obs = {instruction_en, pc_en, pc_src, reg_write, wb_src, alu_b_src, alu_sel,
                flag_en, mem_req, mem_we, addr_src, illegal};

  function automatic logic [16:0] ov(input logic ie, input logic pe, input logic [1:0] ps,
                                     input logic rw, input logic [1:0] ws, input logic abs,
                                     input logic [3:0] as, input logic fe, input logic mr,
                                     input logic mw, input logic ad, input logic il);
    return {ie, pe, ps, rw, ws, abs, as, fe, mr, mw, ad, il};
  endfunction

  // One clock cycle: queue the expectation, check mid-cycle, then advance past the edge.
  task automatic step(input logic [16:0] expv, input string tag);
    logic [16:0] e;
    string       t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero_v = ov(0, 0, 2'd0, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0);
    f_done = ov(1, 1, PC_SRC_INC, 0, 2'd0, 0, ALU_ADD, 0, 1, 0, 0, 0);
    f_wait = ov(0, 0, 2'd0, 0, 2'd0, 0, ALU_ADD, 0, 1, 0, 0, 0);
    ld_req = ov(0, 0, 2'd0, 0, 2'd0, 0, ALU_ADD, 0, 1, 0, 1, 0);
    st_req = ov(0, 0, 2'd0, 0, 2'd0, 0, ALU_ADD, 0, 1, 1, 1, 0);

    reset = 1'b1; mem_ready = 1'b1; cond_true = 1'b0;
    op_code = 4'h0; ext_op_code = 4'h5;
    for (int i = 0; i < 3; i++) step(zero_v, "reset");

    // ADD R-type, zero-wait
    reset = 1'b0;
    step(f_done, "add_fetch");
    step(zero_v, "add_decode");
    step(ov(0, 0, 2'd0, 1, WB_SRC_ALU, 0, ALU_ADD, 1, 0, 0, 0, 0), "add_exec");

    // CMPI
    op_code = OP_CMPI;
    step(f_done, "cmpi_fetch");
    step(zero_v, "cmpi_decode");
    step(ov(0, 0, 2'd0, 0, 2'd0, 1, ALU_SUB, 1, 0, 0, 0, 0), "cmpi_exec");

    // LOAD, memory ready delayed two cycles; ready during DECODE must be ignored
    op_code = OP_SPECIAL; ext_op_code = EXT_LOAD;
    step(f_done, "load_fetch");
    step(zero_v, "load_decode");
    mem_ready = 1'b0;
    step(ld_req, "load_wait1");
    step(ld_req, "load_wait2");
    mem_ready = 1'b1;
    step(ld_req, "load_done");
    mem_ready = 1'b0;
    step(ov(0, 0, 2'd0, 1, WB_SRC_MEM, 0, ALU_ADD, 0, 0, 0, 0, 0), "load_wb");

    // BCOND not taken (with one fetch wait), then taken
    op_code = OP_BCOND; cond_true = 1'b0;
    step(f_wait, "bcond_fetch_wait");
    mem_ready = 1'b1;
    step(f_done, "bcond_fetch");
    step(zero_v, "bcond_decode");
    step(ov(0, 0, PC_SRC_DISP, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0), "bcond_not_taken");
    cond_true = 1'b1;
    step(f_done, "bcond2_fetch");
    step(zero_v, "bcond2_decode");
    step(ov(0, 1, PC_SRC_DISP, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0), "bcond_taken");

    // JAL: link and jump in the same cycle, regardless of cond_true
    cond_true = 1'b0; ext_op_code = EXT_JAL; op_code = OP_SPECIAL;
    step(f_done, "jal_fetch");
    step(zero_v, "jal_decode");
    step(ov(0, 1, PC_SRC_REG, 1, WB_SRC_PC, 0, ALU_ADD, 0, 0, 0, 0, 0), "jal_exec");

    // JCOND not taken
    ext_op_code = EXT_JCOND;
    step(f_done, "jcond_fetch");
    step(zero_v, "jcond_decode");
    step(ov(0, 0, PC_SRC_REG, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 0), "jcond_not_taken");

    // STORE, zero-wait: three cycles then back to FETCH
    ext_op_code = EXT_STOR;
    step(f_done, "store_fetch");
    step(zero_v, "store_decode");
    step(st_req, "store_zero_wait");

    // Illegal op 0x7: one-cycle pulse, then FETCH
    op_code = 4'h7;
    step(f_done, "illegal_fetch");
    step(ov(0, 0, 2'd0, 0, 2'd0, 0, ALU_ADD, 0, 0, 0, 0, 1), "illegal_pulse");
    mem_ready = 1'b0;
    step(f_wait, "illegal_return");

    // STORE with a wait, aborted by reset
    mem_ready = 1'b1; op_code = OP_SPECIAL; ext_op_code = EXT_STOR;
    step(f_done, "store2_fetch");
    step(zero_v, "store2_decode");
    mem_ready = 1'b0;
    step(st_req, "store2_wait");
    reset = 1'b1;
    step(zero_v, "reset_mid_store");
    step(zero_v, "reset_hold");
    reset = 1'b0;
    step(f_wait, "restart_fetch_wait");
    mem_ready = 1'b1;
    step(f_done, "restart_fetch");
    step(zero_v, "restart_decode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
